// File: rtl/mem_bus_arbiter_pkg.sv
// Shared word/select widths, control constants, FSM encodings and bus payload
// for the instruction-fetch / data-stage memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [WORD_W-1:0] ZERO_WORD  = '0;
    localparam logic [SEL_W-1:0]  SEL_ALL    = '1;
    localparam logic              ENABLE     = 1'b1;
    localparam logic              DISABLE    = 1'b0;
    localparam logic              RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } bus_req_t;

    // Instruction fetches are always full-word reads.
    function automatic bus_req_t fetch_req(input logic [WORD_W-1:0] addr);
        bus_req_t r;
        r.we   = DISABLE;
        r.sel  = SEL_ALL;
        r.addr = addr;
        r.data = ZERO_WORD;
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction-fetch and data-stage ports onto one single-port bus,
// favouring data accesses but bounding how long a waiting fetch can be starved.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_ce_i,
    input  logic [WORD_W-1:0]   if_addr_i,

    input  logic                mem_ce_i,
    input  logic                mem_we_i,
    input  logic [SEL_W-1:0]    mem_sel_i,
    input  logic [WORD_W-1:0]   mem_addr_i,
    input  logic [WORD_W-1:0]   mem_data_i,

    output logic [WORD_W-1:0]   if_data_o,
    output logic [WORD_W-1:0]   mem_data_o,

    output logic                stallreq_if_o,
    output logic                stallreq_mem_o,

    output logic                bus_ce_o,
    output logic                bus_we_o,
    output logic [SEL_W-1:0]    bus_sel_o,
    output logic [WORD_W-1:0]   bus_addr_o,
    output logic [WORD_W-1:0]   bus_data_o,

    input  logic [WORD_W-1:0]   bus_data_i,
    input  logic                bus_ack_i
);

    localparam int unsigned CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_next;
    logic              bus_ce;
    bus_req_t          bus_q;
    logic [WORD_W-1:0] if_hold;
    logic [WORD_W-1:0] mem_hold;

    bus_req_t          if_req;
    bus_req_t          mem_req;
    logic              ack_if;
    logic              ack_mem;
    logic              can_arb;
    logic              fetch_wins;
    logic              grant_if;
    logic              grant_mem;

    assign if_req  = fetch_req(if_addr_i);
    assign mem_req = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, data: mem_data_i};

    // An ack only counts while a transfer is outstanding.
    assign ack_if  = bus_ack_i && (state == ST_IF_BUSY);
    assign ack_mem = bus_ack_i && (state == ST_MEM_BUSY);

    // Arbitrate when idle, or in the ack cycle so the next transfer starts without a bubble.
    assign can_arb    = (state == ST_IDLE) || ack_if || ack_mem;
    assign fetch_wins = if_ce_i && (!mem_ce_i || (starve_cnt == STARVE_MAX));
    assign grant_if   = can_arb && fetch_wins;
    assign grant_mem  = can_arb && mem_ce_i && !fetch_wins;

    always_comb begin
        starve_next = starve_cnt;
        if (!if_ce_i || grant_if) begin
            starve_next = '0;
        end else if (grant_mem && (starve_cnt != STARVE_MAX)) begin
            starve_next = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            bus_ce     <= DISABLE;
            bus_q      <= '0;
            if_hold    <= ZERO_WORD;
            mem_hold   <= ZERO_WORD;
        end else begin
            starve_cnt <= starve_next;
            if (ack_if) begin
                if_hold <= bus_data_i;
            end
            if (ack_mem) begin
                mem_hold <= bus_data_i;
            end
            // Requester controls are sampled only here, so they stay frozen while busy.
            if (grant_if) begin
                state  <= ST_IF_BUSY;
                bus_ce <= ENABLE;
                bus_q  <= if_req;
            end else if (grant_mem) begin
                state  <= ST_MEM_BUSY;
                bus_ce <= ENABLE;
                bus_q  <= mem_req;
            end else if (ack_if || ack_mem) begin
                state    <= ST_IDLE;
                bus_ce   <= DISABLE;
                bus_q.we <= DISABLE;
            end
        end
    end

    assign bus_ce_o   = bus_ce;
    assign bus_we_o   = bus_q.we;
    assign bus_sel_o  = bus_q.sel;
    assign bus_addr_o = bus_q.addr;
    assign bus_data_o = bus_q.data;

    // Read data bypasses the hold register in the ack cycle.
    assign if_data_o  = (rst == RST_ENABLE) ? ZERO_WORD : (ack_if  ? bus_data_i : if_hold);
    assign mem_data_o = (rst == RST_ENABLE) ? ZERO_WORD : (ack_mem ? bus_data_i : mem_hold);

    assign stallreq_if_o  = (rst != RST_ENABLE) && if_ce_i  && !ack_if;
    assign stallreq_mem_o = (rst != RST_ENABLE) && mem_ce_i && !ack_mem;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: expected bus transfers are queued when a
// request is driven and popped when the slave acknowledges them.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] if_data_o;
    logic [31:0] mem_data_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;

    int n_cmp = 0;
    int n_bad = 0;
    bus_req_t exp_q[$];

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .if_data_o      (if_data_o),
        .mem_data_o     (mem_data_o),
        .stallreq_if_o  (stallreq_if_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_ce_o       (bus_ce_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_data_o     (bus_data_o),
        .bus_data_i     (bus_data_i),
        .bus_ack_i      (bus_ack_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bus_req_t bus_now();
        return '{we: bus_we_o, sel: bus_sel_o, addr: bus_addr_o, data: bus_data_o};
    endfunction

    function automatic bus_req_t pop_exp();
        bus_req_t e;
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; if_ce_i = 1'b1; mem_ce_i = 1'b1; bus_ack_i = 1'b1; bus_data_i = '1;
        tick(); #1;
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL rst_bus_ce got %b want 0", bus_ce_o); end
        n_cmp++; if (bus_now() !== bus_req_t'(0)) begin n_bad++; $display("FAIL rst_bus_fields got %h want 0", bus_now()); end
        n_cmp++; if (stallreq_if_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall_if got %b want 0", stallreq_if_o); end
        n_cmp++; if (stallreq_mem_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall_mem got %b want 0", stallreq_mem_o); end
        n_cmp++; if (if_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_if_data got %h want 0", if_data_o); end
        n_cmp++; if (mem_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_mem_data got %h want 0", mem_data_o); end
        rst = 1'b0; if_ce_i = 1'b0; mem_ce_i = 1'b0; bus_ack_i = 1'b0; bus_data_i = '0;
    endtask

    task automatic test_fetch();
        int n_hi = 0;
        bus_req_t e;
        tick();
        if_ce_i = 1'b1; if_addr_i = 32'h100;
        exp_q.push_back(fetch_req(32'h100));
        #1;
        n_cmp++; if (stallreq_if_o !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_pre got %b want 1", stallreq_if_o); end
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL fetch_ce_pre got %b want 0", bus_ce_o); end
        tick();
        if_addr_i = 32'h999;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin bus_ack_i = 1'b1; bus_data_i = 32'h2401_0001; end
            #1;
            if (bus_ce_o === 1'b1) n_hi++;
            if (c == 0) begin
                n_cmp++; if (stallreq_if_o !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_wait got %b want 1", stallreq_if_o); end
            end
            if (c == 2) begin
                e = pop_exp();
                n_cmp++; if (bus_now() !== e) begin n_bad++; $display("FAIL fetch_bus got %h want %h", bus_now(), e); end
                n_cmp++; if (if_data_o !== 32'h2401_0001) begin n_bad++; $display("FAIL fetch_data got %h want 24010001", if_data_o); end
                n_cmp++; if (stallreq_if_o !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_ack got %b want 0", stallreq_if_o); end
            end
            tick();
        end
        n_cmp++; if (n_hi !== 3) begin n_bad++; $display("FAIL fetch_ce_cycles got %0d want 3", n_hi); end
        // still requesting in the ack cycle, so a second fetch started back-to-back
        bus_ack_i = 1'b0; bus_data_i = '0; if_ce_i = 1'b0;
        exp_q.push_back(fetch_req(32'h999));
        #1;
        n_cmp++; if (if_data_o !== 32'h2401_0001) begin n_bad++; $display("FAIL fetch_hold got %h want 24010001", if_data_o); end
        n_cmp++; if (bus_ce_o !== 1'b1) begin n_bad++; $display("FAIL fetch_b2b_ce got %b want 1", bus_ce_o); end
        tick();
        bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_0001;
        #1;
        e = pop_exp();
        n_cmp++; if (bus_now() !== e) begin n_bad++; $display("FAIL fetch_b2b_bus got %h want %h", bus_now(), e); end
        n_cmp++; if (if_data_o !== 32'hCAFE_0001) begin n_bad++; $display("FAIL fetch_b2b_data got %h want cafe0001", if_data_o); end
        tick();
        bus_ack_i = 1'b0;
        #1;
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL fetch_idle_ce got %b want 0", bus_ce_o); end
    endtask

    task automatic test_both();
        bus_req_t e;
        tick();
        if_ce_i = 1'b1; if_addr_i = 32'h140;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h200; mem_data_i = 32'hDEAD_BEEF;
        exp_q.push_back('{we: 1'b1, sel: 4'b0011, addr: 32'h200, data: 32'hDEAD_BEEF});
        exp_q.push_back(fetch_req(32'h140));
        #1;
        n_cmp++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b11) begin n_bad++; $display("FAIL both_stall_pre got %b want 11", {stallreq_if_o, stallreq_mem_o}); end
        tick();
        #1;
        e = pop_exp();
        n_cmp++; if (bus_now() !== e) begin n_bad++; $display("FAIL both_mem_bus got %h want %h", bus_now(), e); end
        n_cmp++; if (stallreq_mem_o !== 1'b1) begin n_bad++; $display("FAIL both_stall_mem got %b want 1", stallreq_mem_o); end
        tick();
        mem_ce_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'h0BAD_0001;
        #1;
        n_cmp++; if (mem_data_o !== 32'h0BAD_0001) begin n_bad++; $display("FAIL both_mem_data got %h want 0bad0001", mem_data_o); end
        n_cmp++; if (stallreq_if_o !== 1'b1) begin n_bad++; $display("FAIL both_stall_if got %b want 1", stallreq_if_o); end
        tick();
        bus_ack_i = 1'b0; mem_we_i = 1'b0;
        #1;
        e = pop_exp();
        n_cmp++; if (bus_ce_o !== 1'b1) begin n_bad++; $display("FAIL both_if_ce got %b want 1", bus_ce_o); end
        n_cmp++; if (bus_now() !== e) begin n_bad++; $display("FAIL both_if_bus got %h want %h", bus_now(), e); end
        n_cmp++; if (mem_data_o !== 32'h0BAD_0001) begin n_bad++; $display("FAIL both_mem_hold got %h want 0bad0001", mem_data_o); end
        if_ce_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'h1111_0002;
        #1;
        n_cmp++; if (if_data_o !== 32'h1111_0002) begin n_bad++; $display("FAIL both_if_data got %h want 11110002", if_data_o); end
        tick();
        bus_ack_i = 1'b0;
        #1;
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL both_idle_ce got %b want 0", bus_ce_o); end
    endtask

    task automatic test_starve();
        // grant order with fetch always waiting: four data grants, then fetch, then data again
        logic [5:0] g_pat = 6'b01_0000;
        bus_req_t e;
        tick();
        if_ce_i = 1'b1; if_addr_i = 32'h300;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h400; mem_data_i = '0;
        exp_q.push_back(g_pat[0] ? fetch_req(32'h300) : '{we: 1'b0, sel: 4'hF, addr: 32'h400, data: 32'h0});
        for (int i = 0; i < 6; i++) begin
            tick();
            bus_ack_i = 1'b1; bus_data_i = 32'h5000 + 32'(i);
            mem_addr_i = 32'h400 + 32'(4 * (i + 1));
            if (i < 5) exp_q.push_back(g_pat[i+1] ? fetch_req(32'h300) : '{we: 1'b0, sel: 4'hF, addr: mem_addr_i, data: 32'h0});
            #1;
            e = pop_exp();
            n_cmp++; if (bus_now() !== e) begin n_bad++; $display("FAIL starve_bus_%0d got %h want %h", i, bus_now(), e); end
            if (g_pat[i]) begin
                n_cmp++; if (if_data_o !== 32'h5000 + 32'(i)) begin n_bad++; $display("FAIL starve_if_data_%0d got %h want %h", i, if_data_o, 32'h5000 + 32'(i)); end
                n_cmp++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b01) begin n_bad++; $display("FAIL starve_stall_%0d got %b want 01", i, {stallreq_if_o, stallreq_mem_o}); end
            end else begin
                n_cmp++; if (mem_data_o !== 32'h5000 + 32'(i)) begin n_bad++; $display("FAIL starve_mem_data_%0d got %h want %h", i, mem_data_o, 32'h5000 + 32'(i)); end
                n_cmp++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b10) begin n_bad++; $display("FAIL starve_stall_%0d got %b want 10", i, {stallreq_if_o, stallreq_mem_o}); end
            end
            if (i == 5) begin if_ce_i = 1'b0; mem_ce_i = 1'b0; end
        end
        tick();
        bus_ack_i = 1'b0;
        #1;
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL starve_idle_ce got %b want 0", bus_ce_o); end
    endtask

    task automatic test_reset_mid();
        tick();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h600;
        tick();
        mem_ce_i = 1'b0; rst = 1'b1;
        #1;
        n_cmp++; if (mem_data_o !== 32'h0) begin n_bad++; $display("FAIL rmid_data_in_rst got %h want 0", mem_data_o); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL rmid_ce got %b want 0", bus_ce_o); end
        tick();
        bus_ack_i = 1'b1; bus_data_i = 32'h7777_7777;
        #1;
        n_cmp++; if (mem_data_o !== 32'h0) begin n_bad++; $display("FAIL rmid_late_ack_data got %h want 0", mem_data_o); end
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0;
        #1;
        n_cmp++; if (mem_data_o !== 32'h0) begin n_bad++; $display("FAIL rmid_hold got %h want 0", mem_data_o); end
        n_cmp++; if (if_data_o !== 32'h0) begin n_bad++; $display("FAIL rmid_if_hold got %h want 0", if_data_o); end
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL rmid_idle_ce got %b want 0", bus_ce_o); end
    endtask

    task automatic test_drop();
        bus_req_t e;
        tick();
        if_ce_i = 1'b1; if_addr_i = 32'h700;
        exp_q.push_back(fetch_req(32'h700));
        tick();
        if_ce_i = 1'b0;
        #1;
        n_cmp++; if (stallreq_if_o !== 1'b0) begin n_bad++; $display("FAIL drop_stall got %b want 0", stallreq_if_o); end
        tick();
        bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
        #1;
        e = pop_exp();
        n_cmp++; if (bus_now() !== e) begin n_bad++; $display("FAIL drop_bus got %h want %h", bus_now(), e); end
        n_cmp++; if (stallreq_if_o !== 1'b0) begin n_bad++; $display("FAIL drop_stall_ack got %b want 0", stallreq_if_o); end
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0;
        #1;
        n_cmp++; if (if_data_o !== 32'h1234_5678) begin n_bad++; $display("FAIL drop_hold got %h want 12345678", if_data_o); end
        n_cmp++; if (bus_ce_o !== 1'b0) begin n_bad++; $display("FAIL drop_idle_ce got %b want 0", bus_ce_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_ce_i = 1'b0; if_addr_i = '0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
        bus_ack_i = 1'b0; bus_data_i = '0;
        test_reset();
        test_fetch();
        test_both();
        test_starve();
        test_reset_mid();
        test_drop();
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
